sseg_scan_decoder: RTL and testbench

//  Receive-side counterpart of the hex-to-7-segment encoder. Samples a multiplexed,

---
 rtl/sseg_scan_decoder.sv | 195 +++++++++++++++++++
 tb/tb_sseg_scan_decoder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_decoder.sv
// Recovers the hex nibbles shown on a multiplexed active-low common-anode 7-segment bus.
// Filters short scan glitches, flags unknown patterns and publishes one word per full scan.
module sseg_scan_decoder #(
    parameter int NDIG   = 4,
    parameter int STABLE = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NDIG-1:0]     an_n,
    input  logic [6:0]          seg_n,
    output logic [4*NDIG-1:0]   value,
    output logic                valid,
    output logic [NDIG-1:0]     digit_err,
    output logic                frame_err
);

    localparam int CW = $clog2(STABLE + 1);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        BLANK  = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Returns {err, nibble}; unknown patterns decode to nibble 0 with err set.
    function automatic logic [4:0] seg_decode(input logic [6:0] pat);
        case (pat)
            7'h40:   seg_decode = 5'h00;
            7'h79:   seg_decode = 5'h01;
            7'h24:   seg_decode = 5'h02;
            7'h30:   seg_decode = 5'h03;
            7'h19:   seg_decode = 5'h04;
            7'h12:   seg_decode = 5'h05;
            7'h02:   seg_decode = 5'h06;
            7'h78:   seg_decode = 5'h07;
            7'h00:   seg_decode = 5'h08;
            7'h10:   seg_decode = 5'h09;
            7'h08:   seg_decode = 5'h0A;
            7'h03:   seg_decode = 5'h0B;
            7'h46:   seg_decode = 5'h0C;
            7'h21:   seg_decode = 5'h0D;
            7'h06:   seg_decode = 5'h0E;
            7'h0E:   seg_decode = 5'h0F;
            default: seg_decode = 5'h10;
        endcase
    endfunction

    logic [NDIG-1:0]   an_r;
    logic [6:0]        seg_r;
    logic [NDIG-1:0]   prev_an_r;
    logic [6:0]        prev_seg_r;
    state_t            state_r;
    state_t            state_s;
    logic [CW-1:0]     cnt_r;
    logic [CW-1:0]     cnt_s;
    logic              capture_s;
    logic [3:0]        zero_cnt_s;
    logic [IW-1:0]     dig_idx_s;
    logic              one_cold_s;
    logic              illegal_s;
    logic              same_s;
    logic [4:0]        dec_s;
    logic              publish_s;
    logic [NDIG-1:0]   seen_r;
    logic [NDIG-1:0]   seen_s;
    logic [4*NDIG-1:0] shadow_r;
    logic [NDIG-1:0]   err_shadow_r;

    // Classify the registered anode sample and locate the selected digit.
    always_comb begin
        zero_cnt_s = 4'd0;
        dig_idx_s  = '0;
        for (int i = 0; i < NDIG; i++) begin
            zero_cnt_s = zero_cnt_s + {3'b000, ~an_r[i]};
            dig_idx_s  = an_r[i] ? dig_idx_s : IW'(i);
        end
        one_cold_s = (zero_cnt_s == 4'd1);
        illegal_s  = (zero_cnt_s > 4'd1);
        same_s     = (an_r == prev_an_r) && (seg_r == prev_seg_r);
        dec_s      = seg_decode(seg_r);
        publish_s  = &seen_r;
        seen_s     = (publish_s ? {NDIG{1'b0}} : seen_r) | ({NDIG{capture_s}} & ~an_r);
    end

    // Next-state logic: a digit is captured once STABLE identical samples are seen.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        capture_s = 1'b0;
        case (state_r)
            BLANK: begin
                if (one_cold_s) begin
                    state_s = TRACK;
                    cnt_s   = CW'(1);
                end else begin
                    state_s = BLANK;
                    cnt_s   = '0;
                end
            end
            TRACK: begin
                if (!one_cold_s) begin
                    state_s = BLANK;
                    cnt_s   = '0;
                end else if (same_s) begin
                    if (cnt_r >= CW'(STABLE - 1)) begin
                        state_s   = LOCKED;
                        cnt_s     = CW'(STABLE);
                        capture_s = 1'b1;
                    end else begin
                        state_s = TRACK;
                        cnt_s   = cnt_r + CW'(1);
                    end
                end else begin
                    state_s = TRACK;
                    cnt_s   = CW'(1);
                end
            end
            LOCKED: begin
                if (!one_cold_s) begin
                    state_s = BLANK;
                    cnt_s   = '0;
                end else if (same_s) begin
                    state_s = LOCKED;
                    cnt_s   = cnt_r;
                end else begin
                    state_s = TRACK;
                    cnt_s   = CW'(1);
                end
            end
            default: begin
                state_s = BLANK;
                cnt_s   = '0;
            end
        endcase
    end

    // Input sampling, previous-sample copy and FSM state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_r       <= '1;
            seg_r      <= '1;
            prev_an_r  <= '1;
            prev_seg_r <= '1;
            state_r    <= BLANK;
            cnt_r      <= '0;
        end else begin
            an_r       <= an_n;
            seg_r      <= seg_n;
            prev_an_r  <= an_r;
            prev_seg_r <= seg_r;
            state_r    <= state_s;
            cnt_r      <= cnt_s;
        end
    end

    // Per-digit shadow word; a capture during publish starts the next word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_r     <= '0;
            err_shadow_r <= '0;
            seen_r       <= '0;
        end else begin
            seen_r <= seen_s;
            if (capture_s) begin
                shadow_r[{dig_idx_s, 2'b00} +: 4] <= dec_s[3:0];
                err_shadow_r[dig_idx_s]           <= dec_s[4];
            end else begin
                shadow_r     <= shadow_r;
                err_shadow_r <= err_shadow_r;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value     <= '0;
            digit_err <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= publish_s;
            frame_err <= illegal_s;
            if (publish_s) begin
                value     <= shadow_r;
                digit_err <= err_shadow_r;
            end else begin
                value     <= value;
                digit_err <= digit_err;
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed bench for sseg_scan_decoder: a run-length based reference model is
// compared against the DUT after every clock, plus hand-computed literal expectations.
module tb_sseg_scan_decoder;

    localparam int NDIG   = 4;
    localparam int STABLE = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  an_n = 4'hF;
    logic [6:0]  seg_n = 7'h7F;
    logic [15:0] value;
    logic        valid;
    logic [3:0]  digit_err;
    logic        frame_err;

    sseg_scan_decoder #(.NDIG(NDIG), .STABLE(STABLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .an_n      (an_n),
        .seg_n     (seg_n),
        .value     (value),
        .valid     (valid),
        .digit_err (digit_err),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int frame_cnt = 0;
    int last_valid_cyc = -1;
    int t0 = 0;

    // Reference model state: what the DUT has sampled and the word being assembled.
    logic [3:0]  m_an, m_prev_an, m_seen, m_eshadow;
    logic [6:0]  m_seg, m_prev_seg;
    logic [15:0] m_shadow;
    int          run;
    logic [15:0] exp_value;
    logic        exp_valid, exp_frame;
    logic [3:0]  exp_derr;
    logic [6:0]  pat_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // A digit is captured when a run of identical one-cold samples reaches STABLE;
    // the word is published on the clock after every digit has been captured.
    task automatic model_step(input logic rst_in, input logic [3:0] a, input logic [6:0] g);
        int zeros;
        int d;
        logic [3:0] nib;
        logic err;
        if (!rst_in) begin
            m_an = 4'hF; m_seg = 7'h7F; m_prev_an = 4'hF; m_prev_seg = 7'h7F;
            run = 0; m_seen = 4'h0; m_shadow = 16'h0; m_eshadow = 4'h0;
            exp_value = 16'h0; exp_valid = 1'b0; exp_derr = 4'h0; exp_frame = 1'b0;
        end else begin
            zeros = 0;
            d = 0;
            for (int i = 0; i < NDIG; i++)
                if (!m_an[i]) begin
                    zeros++;
                    d = i;
                end
            exp_frame = (zeros > 1);
            exp_valid = (m_seen == 4'hF);
            if (exp_valid) begin
                exp_value = m_shadow;
                exp_derr  = m_eshadow;
                m_seen    = 4'h0;
            end
            if (zeros == 1)
                run = (run > 0 && m_an == m_prev_an && m_seg == m_prev_seg) ? run + 1 : 1;
            else
                run = 0;
            if (run == STABLE) begin
                nib = 4'h0;
                err = 1'b1;
                for (int v = 0; v < 16; v++)
                    if (pat_tab[v] == m_seg) begin
                        nib = v[3:0];
                        err = 1'b0;
                    end
                m_shadow[4*d +: 4] = nib;
                m_eshadow[d] = err;
                m_seen[d] = 1'b1;
            end
            m_prev_an = m_an;
            m_prev_seg = m_seg;
            m_an = a;
            m_seg = g;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(rst_n, an_n, seg_n);
        #1;
        cyc++;
        check("value", {16'h0, value}, {16'h0, exp_value});
        check("valid", {31'h0, valid}, {31'h0, exp_valid});
        check("digit_err", {28'h0, digit_err}, {28'h0, exp_derr});
        check("frame_err", {31'h0, frame_err}, {31'h0, exp_frame});
        if (valid) begin
            valid_cnt++;
            last_valid_cyc = cyc;
        end
        if (frame_err) frame_cnt++;
    endtask

    task automatic show(input int d, input logic [6:0] pat, input int n);
        an_n  = ~(4'b0001 << d);
        seg_n = pat;
        repeat (n) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        check("reset_value", {16'h0, value}, 32'h0);
        check("reset_valid", {31'h0, valid}, 32'h0);
        rst_n = 1'b1;

        // 1: clean scan 1,2,3,4 and completing-digit latency
        valid_cnt = 0;
        show(0, 7'h79, 20);
        show(1, 7'h24, 20);
        show(2, 7'h30, 20);
        t0 = cyc;
        show(3, 7'h19, 20);
        check("t1_value", {16'h0, value}, 32'h4321);
        check("t1_derr", {28'h0, digit_err}, 32'h0);
        check("t1_valid_cnt", valid_cnt, 1);
        check("t1_latency", last_valid_cyc - t0, 10);

        // 2: short glitch on digit 1 is never captured
        valid_cnt = 0;
        show(0, 7'h79, 20);
        show(1, 7'h24, 5);
        show(1, 7'h46, 20);
        show(2, 7'h30, 20);
        show(3, 7'h19, 20);
        check("t2_value", {16'h0, value}, 32'h43C1);
        check("t2_nibble1", {28'h0, value[7:4]}, 32'hC);
        check("t2_valid_cnt", valid_cnt, 1);

        // 3: non-hex pattern on digit 2
        valid_cnt = 0;
        show(0, 7'h40, 20);
        show(1, 7'h79, 20);
        show(2, 7'h7F, 20);
        show(3, 7'h24, 20);
        check("t3_value", {16'h0, value}, 32'h2010);
        check("t3_derr", {28'h0, digit_err}, 32'h4);
        check("t3_valid_cnt", valid_cnt, 1);

        // 4: two anodes low -> frame_err per sample, nothing captured
        valid_cnt = 0;
        frame_cnt = 0;
        an_n = 4'b1100;
        seg_n = 7'h40;
        repeat (3) tick();
        an_n = 4'hF;
        repeat (4) tick();
        check("t4_frame_cnt", frame_cnt, 3);
        check("t4_valid_cnt", valid_cnt, 0);

        // 5: long hold after a full scan yields a single capture
        valid_cnt = 0;
        show(0, 7'h00, 20);
        show(1, 7'h00, 20);
        show(2, 7'h00, 20);
        show(3, 7'h00, 20);
        show(0, 7'h00, 200);
        check("t5_value", {16'h0, value}, 32'h8888);
        check("t5_valid_cnt", valid_cnt, 1);

        // 6: reset after a partial word discards it
        show(0, 7'h06, 20);
        show(1, 7'h0E, 20);
        show(2, 7'h40, 20);
        rst_n = 1'b0;
        tick();
        check("t6_rst_value", {16'h0, value}, 32'h0);
        check("t6_rst_derr", {28'h0, digit_err}, 32'h0);
        rst_n = 1'b1;
        valid_cnt = 0;
        show(0, 7'h06, 20);
        show(1, 7'h0E, 20);
        show(2, 7'h40, 20);
        show(3, 7'h08, 20);
        check("t6_value", {16'h0, value}, 32'hA0FE);
        check("t6_derr", {28'h0, digit_err}, 32'h0);
        check("t6_valid_cnt", valid_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
